// File: rtl/meter_slew_ctrl.sv
// Slew-limited duty controller for the hour/minute/second meters, with a full-scale sweep self-test.
// Duties move only on slew ticks (every TICK_DIV clocks); strobes are always accepted, nothing stalls.
module meter_slew_ctrl #(
   parameter int SYSCLKHZ      = 10_000_000,
   parameter int TICK_DIV      = 100_000,
   parameter int STEP          = 2,
   parameter int FULL_SCALE    = 255,
   parameter int HOLD_TICKS    = 50,
   parameter int STARTUP_SWEEP = 1
) (
   input  logic       clk,
   input  logic       Rst_n,
   input  logic       tgt_valid,
   input  logic [7:0] target_h,
   input  logic [7:0] target_m,
   input  logic [7:0] target_s,
   input  logic       sweep_req,
   output logic [7:0] duty_h,
   output logic [7:0] duty_m,
   output logic [7:0] duty_s,
   output logic       busy,
   output logic       sweep_done,
   output logic       settled
);

   localparam int TW = $clog2(TICK_DIV);
   localparam int HW = $clog2(HOLD_TICKS + 1);
   localparam logic [7:0] FS = 8'(FULL_SCALE);
   localparam logic [7:0] ST = 8'(STEP);

   typedef enum logic [1:0] {S_SWEEP_UP, S_HOLD, S_SWEEP_DOWN, S_TRACK} state_t;
   localparam state_t S_RST = (STARTUP_SWEEP != 0) ? S_SWEEP_UP : S_TRACK;

   if (TICK_DIV < 2 || STEP < 1 || STEP > 255 || HOLD_TICKS < 1 || SYSCLKHZ < 1) begin : g_bad_param
      $error("meter_slew_ctrl: illegal parameter value");
   end

   state_t          r_state, w_state_nxt;
   logic [TW-1:0]   r_tick_cnt;
   logic [HW-1:0]   r_hold_cnt;
   logic [2:0][7:0] r_duty, w_duty_nxt;
   logic [2:0][7:0] r_tgt;
   logic            r_pend;
   logic            r_sweep_done;
   logic            w_tick, w_all_fs, w_all_zero, w_at_tgt, w_done_nxt;

   function automatic logic [7:0] f_up(input logic [7:0] d);
      logic [8:0] sum;
      sum = {1'b0, d} + {1'b0, ST};
      return (sum >= {1'b0, FS}) ? FS : sum[7:0];
   endfunction

   function automatic logic [7:0] f_dn(input logic [7:0] d);
      return (d <= ST) ? 8'd0 : d - ST;
   endfunction

   // Snap to target when within one step, otherwise move exactly one step towards it.
   function automatic logic [7:0] f_trk(input logic [7:0] d, input logic [7:0] t);
      if (t >= d) return ((t - d) <= ST) ? t : d + ST;
      else        return ((d - t) <= ST) ? t : d - ST;
   endfunction

   function automatic logic [7:0] f_clamp(input logic [7:0] t);
      return (t > FS) ? FS : t;
   endfunction

   assign w_tick     = (r_tick_cnt == TW'(TICK_DIV - 1));
   assign w_all_fs   = (r_duty[0] == FS) && (r_duty[1] == FS) && (r_duty[2] == FS);
   assign w_all_zero = (r_duty[0] == 8'd0) && (r_duty[1] == 8'd0) && (r_duty[2] == 8'd0);
   assign w_at_tgt   = (r_duty == r_tgt);

   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) r_state <= S_RST;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_tick) begin
         case (r_state)
            S_SWEEP_UP:   if (w_all_fs) w_state_nxt = S_HOLD;
            S_HOLD:       if (r_hold_cnt == HW'(HOLD_TICKS)) w_state_nxt = S_SWEEP_DOWN;
            S_SWEEP_DOWN: if (w_all_zero) w_state_nxt = S_TRACK;
            default:      if (r_pend) w_state_nxt = S_SWEEP_UP;
         endcase
      end
   end

   always_comb begin
      w_duty_nxt = r_duty;
      w_done_nxt = 1'b0;
      if (w_tick) begin
         case (r_state)
            S_SWEEP_UP: begin
               for (int i = 0; i < 3; i++) w_duty_nxt[i] = f_up(r_duty[i]);
            end
            S_SWEEP_DOWN: begin
               for (int i = 0; i < 3; i++) w_duty_nxt[i] = f_dn(r_duty[i]);
               w_done_nxt = w_all_zero;
            end
            S_TRACK: begin
               // The tick that launches a pending sweep holds the duties.
               if (!r_pend) begin
                  for (int i = 0; i < 3; i++) w_duty_nxt[i] = f_trk(r_duty[i], r_tgt[i]);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge Rst_n) begin
      if (!Rst_n) begin
         r_tick_cnt   <= '0;
         r_hold_cnt   <= '0;
         r_duty       <= '0;
         r_tgt        <= '0;
         r_pend       <= 1'b0;
         r_sweep_done <= 1'b0;
      end else begin
         r_tick_cnt   <= w_tick ? '0 : r_tick_cnt + TW'(1);
         r_duty       <= w_duty_nxt;
         r_sweep_done <= w_done_nxt;
         if (tgt_valid) r_tgt <= {f_clamp(target_s), f_clamp(target_m), f_clamp(target_h)};
         if (w_tick && r_state == S_TRACK && r_pend)   r_pend <= 1'b0;
         else if (sweep_req && r_state == S_TRACK)     r_pend <= 1'b1;
         if (w_tick) begin
            if (r_state == S_SWEEP_UP && w_all_fs)
               r_hold_cnt <= '0;
            else if (r_state == S_HOLD && r_hold_cnt != HW'(HOLD_TICKS))
               r_hold_cnt <= r_hold_cnt + HW'(1);
         end
      end
   end

   assign duty_h     = r_duty[0];
   assign duty_m     = r_duty[1];
   assign duty_s     = r_duty[2];
   assign sweep_done = r_sweep_done;
   assign busy       = (r_state != S_TRACK) || r_pend;
   assign settled    = (r_state == S_TRACK) && !r_pend && w_at_tgt;

endmodule

// File: tb/tb_meter_slew_ctrl.sv
// Directed bench for meter_slew_ctrl: startup sweep, tracking, clamping, sweep requests and reset.
module tb_meter_slew_ctrl;

   logic       clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic       tgt_valid = 1'b0;
   logic       sweep_req = 1'b0;
   logic [7:0] target_h = '0, target_m = '0, target_s = '0;
   logic [7:0] duty_h, duty_m, duty_s;
   logic       busy, sweep_done, settled;

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;

   meter_slew_ctrl #(
      .SYSCLKHZ(10_000_000), .TICK_DIV(4), .STEP(8), .FULL_SCALE(200),
      .HOLD_TICKS(2), .STARTUP_SWEEP(1)
   ) dut (
      .clk(clk), .Rst_n(Rst_n), .tgt_valid(tgt_valid),
      .target_h(target_h), .target_m(target_m), .target_s(target_s),
      .sweep_req(sweep_req), .duty_h(duty_h), .duty_m(duty_m), .duty_s(duty_s),
      .busy(busy), .sweep_done(sweep_done), .settled(settled)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (sweep_done) done_cnt++;

   task automatic chk(input string tag, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   task automatic chk_duty(input string tag, input int h, input int m, input int s);
      chk({tag, "_h"}, duty_h, h);
      chk({tag, "_m"}, duty_m, m);
      chk({tag, "_s"}, duty_s, s);
   endtask

   function automatic int mn(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic tick_step();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic tv, input int h, input int m, input int s, input logic sr);
      tgt_valid = tv;
      target_h  = 8'(h);
      target_m  = 8'(m);
      target_s  = 8'(s);
      sweep_req = sr;
      @(posedge clk);
      #1;
      tgt_valid = 1'b0;
      sweep_req = 1'b0;
   endtask

   task automatic finish_tick();
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input string tag);
      int got;
      got = 0;
      for (int i = 0; i < 80 && got == 0; i++) begin
         tick_step();
         if (sweep_done) got = 1;
      end
      chk(tag, got, 1);
   endtask

   initial begin
      int seen, found, n;
      repeat (2) @(posedge clk);
      #1;
      chk_duty("rst", 0, 0, 0);
      chk("rst_busy", busy, 1);
      chk("rst_settled", settled, 0);
      chk("rst_done", sweep_done, 0);
      Rst_n = 1'b1;

      // Startup sweep: up 25 ticks, 4 ticks at full scale, down 25, then TRACK.
      for (int k = 1; k <= 25; k++) begin
         tick_step();
         chk_duty("t1_up", mn(8 * k, 200), mn(8 * k, 200), mn(8 * k, 200));
      end
      for (int k = 1; k <= 4; k++) begin
         tick_step();
         chk_duty("t1_hold", 200, 200, 200);
      end
      chk("t1_busy", busy, 1);
      for (int k = 1; k <= 25; k++) begin
         tick_step();
         chk_duty("t1_dn", 200 - 8 * k, 200 - 8 * k, 200 - 8 * k);
      end
      chk("t1_done_early", done_cnt, 0);
      tick_step();
      chk("t1_done", sweep_done, 1);
      chk("t1_busy_end", busy, 0);
      chk("t1_settled", settled, 1);
      tick_step();
      chk("t1_done_cnt", done_cnt, 1);
      chk("t1_done_low", sweep_done, 0);

      // Tracking with clamping of an over-range minute target.
      for (int k = 1; k <= 25; k++) begin
         if (k == 1) begin
            pulse(1'b1, 20, 250, 0, 1'b0);
            finish_tick();
         end else tick_step();
         chk_duty("t2", mn(8 * k, 20), mn(8 * k, 200), 0);
         chk("t2_settled", settled, (k == 25) ? 1 : 0);
      end

      // Full-scale drop of the second hand, no underflow.
      pulse(1'b1, 200, 200, 200, 1'b0);
      finish_tick();
      repeat (24) tick_step();
      chk_duty("t3_full", 200, 200, 200);
      chk("t3_settled_full", settled, 1);
      for (int k = 1; k <= 25; k++) begin
         if (k == 1) begin
            pulse(1'b1, 200, 200, 0, 1'b0);
            finish_tick();
         end else tick_step();
         chk("t3_s", duty_s, 200 - 8 * k);
      end
      tick_step();
      chk("t3_s_floor", duty_s, 0);
      chk("t3_settled", settled, 1);

      // Target written during HOLD takes effect only after the sweep.
      pulse(1'b0, 0, 0, 0, 1'b1);
      chk("t4_busy_req", busy, 1);
      finish_tick();
      chk_duty("t4_launch", 200, 200, 0);
      for (int k = 1; k <= 25; k++) begin
         tick_step();
         chk_duty("t4_up", 200, 200, mn(8 * k, 200));
      end
      tick_step();
      pulse(1'b1, 100, 0, 0, 1'b0);
      finish_tick();
      chk_duty("t4_hold", 200, 200, 200);
      wait_done("t4_done_seen");
      chk_duty("t4_end", 0, 0, 0);
      chk("t4_settled_end", settled, 0);
      for (int k = 1; k <= 13; k++) begin
         tick_step();
         chk_duty("t4_trk", mn(8 * k, 100), 0, 0);
      end
      chk("t4_settled", settled, 1);

      // Sweep request and new targets in the same cycle.
      pulse(1'b1, 40, 40, 40, 1'b0);
      finish_tick();
      repeat (7) tick_step();
      chk_duty("t5_pre", 40, 40, 40);
      pulse(1'b1, 16, 16, 16, 1'b1);
      chk("t5_busy", busy, 1);
      chk("t5_settled", settled, 0);
      finish_tick();
      chk_duty("t5_launch", 40, 40, 40);
      tick_step();
      chk_duty("t5_up1", 48, 48, 48);
      wait_done("t5_done_seen");
      chk_duty("t5_end", 0, 0, 0);
      tick_step();
      chk_duty("t5_trk1", 8, 8, 8);
      tick_step();
      chk_duty("t5_trk2", 16, 16, 16);
      chk("t5_settled_end", settled, 1);

      // Asynchronous reset while sweeping down through 120.
      pulse(1'b0, 0, 0, 0, 1'b1);
      finish_tick();
      seen = 0;
      found = 0;
      n = 0;
      while (found == 0 && n < 100) begin
         tick_step();
         n++;
         if (duty_h == 8'd200) seen = 1;
         if (seen == 1 && duty_h == 8'd120) found = 1;
      end
      chk("t6_reach_120", found, 1);
      Rst_n = 1'b0;
      #1;
      chk_duty("t6_async", 0, 0, 0);
      chk("t6_busy", busy, 1);
      chk("t6_settled", settled, 0);
      @(posedge clk);
      #1;
      Rst_n = 1'b1;
      tick_step();
      chk_duty("t6_restart1", 8, 8, 8);
      tick_step();
      chk_duty("t6_restart2", 16, 16, 16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
